cmd_fifo_writer: RTL and testbench
==================================

CMD_FIFO_WRITER -- requirements
Module: cmd_fifo_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 72, meaning the FIFO word width in bits; it must be a multiple of 8.
REQ-002 SHALL have parameter NBYTES, default WIDTH/8, meaning the number of bytes per command word.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the idle cycles allowed mid-command before abort.
REQ-004 SHALL have port wr_clk, input, 1 bit: the write-domain clock; all logic runs on its rising edge.
REQ-005 SHALL have port wr_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: a byte is offered on in_data.
REQ-007 SHALL have port in_data, input, 8 bits: the command byte.
REQ-008 SHALL have port in_frame_start, input, 1 bit: qualifies the offered byte as byte 0 of a command.
REQ-009 SHALL have port in_ready, output, 1 bit: a byte is accepted on any cycle where in_valid and in_ready are both high.
REQ-010 SHALL have port fifo_wr_en, output, 1 bit: the push strobe to the async FIFO write port.
REQ-011 SHALL have port fifo_wr_data, output, WIDTH bits: the assembled command word.
REQ-012 SHALL have port fifo_full, input, 1 bit: the FIFO full flag in the write domain.
REQ-013 SHALL have port fifo_almost_full, input, 1 bit: the FIFO depth-2 threshold flag.
REQ-014 SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-015 SHALL have port drop_count, output, 8 bits: the count of discarded bytes/commands; it saturates at 255.
REQ-016 SHALL have port timeout_err, output, 1 bit: a single-cycle pulse on timeout abort.

Function
REQ-017 SHALL implement the FSM states IDLE, COLLECT and PUSH.
REQ-018 SHALL, in IDLE with in_ready=1, behave as follows:
- An accepted byte with in_frame_start=1 is stored as byte 0, sets byte index=1, and moves the FSM to COLLECT; if NBYTES==1, it moves directly to PUSH.
- An accepted byte with in_frame_start=0 is discarded and drop_count increments.
REQ-019 SHALL place bytes MSB-first: byte k goes to fifo_wr_data[WIDTH-1-8k -: 8].
REQ-020 SHALL, in COLLECT, store each accepted byte at the current index and increment the index; acceptance of byte NBYTES-1 moves the FSM to PUSH on the next edge.
REQ-021 SHALL, in COLLECT, treat an accepted byte with in_frame_start=1 as a restart: the partial word is discarded, drop_count increments, the byte becomes byte 0, and index=1.
REQ-022 SHALL drive in_ready=1 in COLLECT, in_ready=0 in PUSH, and in_ready=!fifo_almost_full in IDLE, so no new command starts near full.
REQ-023 SHALL drive fifo_wr_en combinationally as (state==PUSH) && !fifo_full; the FSM leaves PUSH to IDLE on the edge where fifo_wr_en=1.
REQ-024 SHALL hold fifo_wr_data stable for the whole of PUSH; latency from acceptance of the last byte to fifo_wr_en is exactly 1 cycle when fifo_full=0.
REQ-025 SHALL, in PUSH with fifo_full=1, wait indefinitely with no data loss and no push.
REQ-026 SHALL assert fifo_wr_en for exactly one cycle per command; it is never asserted while fifo_full=1.
REQ-027 SHALL increment drop_count by at most 1 per cycle and stick at 255.

Reset
REQ-028 SHALL, on wr_rst_n low, asynchronously set:
- state=IDLE, index=0, fifo_wr_data=0;
- drop_count=0, timeout_err=0, busy=0, fifo_wr_en=0;
- the idle counter to 0.
REQ-029 SHALL discard any partial or pending command on a mid-command reset; after release, the first valid command is pushed normally.
REQ-030 SHALL drive in_ready during reset as !fifo_almost_full, since the FSM is in IDLE.

Configuration
REQ-031 SHALL, with macro CMD_FIFO_WRITER_TIMEOUT_EN defined, run an idle counter in COLLECT:
- The counter clears on every accepted byte and increments on cycles without acceptance.
- On reaching TIMEOUT_CYCLES, the partial word is discarded, state goes to IDLE, timeout_err pulses for 1 cycle, and drop_count increments.
REQ-032 SHALL, without CMD_FIFO_WRITER_TIMEOUT_EN, include no counter; timeout_err is tied to 0 and COLLECT waits indefinitely.

Verification
REQ-033 SHALL cover a single command: 9 back-to-back bytes 0x01..0x09 with frame_start on the first -> one fifo_wr_en pulse, 1 cycle after the last byte, with data 0x010203040506070809.
REQ-034 SHALL cover a push against a full FIFO: fifo_full=1 when PUSH is entered, released after 20 cycles -> no push for 20 cycles, then one push with data unchanged, and in_ready=0 throughout.
REQ-035 SHALL cover a restart: frame_start on byte 4 of a command, then 8 more bytes -> drop_count=1 and one push whose word starts with the restart byte.
REQ-036 SHALL cover stray bytes: 3 bytes without frame_start in IDLE -> drop_count=3 and no push.
REQ-037 SHALL cover backpressure: fifo_almost_full=1 in IDLE -> in_ready=0; in COLLECT, in_ready stays 1.
REQ-038 SHALL cover timeout (macro defined, TIMEOUT_CYCLES=16): 4 bytes, then idle -> timeout_err pulse 16 cycles after the last byte, state IDLE, drop_count=1; a reset mid-command -> all outputs per REQ-028.

Source files
------------

// File: rtl/cmd_fifo_writer.sv
// Byte-to-word command assembler feeding the write port of an async command FIFO.
// Optional mid-command idle timeout is compiled in with `define CMD_FIFO_WRITER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for a frame-start byte; stray bytes are dropped
// COLLECT | gathering bytes 1..NBYTES-1 of the current command
// PUSH    | word complete, held until the FIFO accepts it
module cmd_fifo_writer #(
   parameter int WIDTH          = 72,
   parameter int NBYTES         = WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             wr_clk,
   input  logic             wr_rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_frame_start,
   output logic             in_ready,
   output logic             fifo_wr_en,
   output logic [WIDTH-1:0] fifo_wr_data,
   input  logic             fifo_full,
   input  logic             fifo_almost_full,
   output logic             busy,
   output logic [7:0]       drop_count,
   output logic             timeout_err
);

   localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES + 1) : 1;

   if ((WIDTH % 8) != 0 || NBYTES < 1 || NBYTES * 8 > WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("cmd_fifo_writer: illegal WIDTH/NBYTES/TIMEOUT_CYCLES combination");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PUSH    = 2'd2
   } state_t;

   state_t             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic [WIDTH-1:0]   word_q;
   logic [WIDTH-1:0]   word_ins_d;
   logic [WIDTH-1:0]   word_first_d;
   logic [7:0]         drop_q;
   logic [7:0]         drop_inc_d;
   logic               accept;

   assign in_ready     = (state_q == IDLE)    ? !fifo_almost_full :
                         (state_q == COLLECT) ? 1'b1 : 1'b0;
   assign accept       = in_valid && in_ready;
   assign fifo_wr_en   = (state_q == PUSH) && !fifo_full;
   assign fifo_wr_data = word_q;
   assign busy         = (state_q != IDLE);
   assign drop_count   = drop_q;
   assign drop_inc_d   = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

   // A new frame always starts from a clean word so stale bytes never leak into a push.
   assign word_first_d = WIDTH'(in_data) << (WIDTH - 8);

   always_comb begin
      word_ins_d = word_q;
      for (int k = 0; k < NBYTES; k++) begin
         if (idx_q == IDX_W'(k)) word_ins_d[WIDTH-1-8*k -: 8] = in_data;
      end
   end

`ifdef CMD_FIFO_WRITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] idle_cnt_q;
   logic             timeout_err_q;
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         word_q        <= '0;
         drop_q        <= '0;
`ifdef CMD_FIFO_WRITER_TIMEOUT_EN
         idle_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
`ifdef CMD_FIFO_WRITER_TIMEOUT_EN
         timeout_err_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (in_frame_start) begin
                     word_q  <= word_first_d;
                     idx_q   <= IDX_W'(1);
                     state_q <= (NBYTES == 1) ? PUSH : COLLECT;
`ifdef CMD_FIFO_WRITER_TIMEOUT_EN
                     idle_cnt_q <= '0;
`endif
                  end else begin
                     drop_q <= drop_inc_d;
                  end
               end
            end
            COLLECT: begin
               if (accept) begin
`ifdef CMD_FIFO_WRITER_TIMEOUT_EN
                  idle_cnt_q <= '0;
`endif
                  if (in_frame_start) begin
                     drop_q <= drop_inc_d;
                     word_q <= word_first_d;
                     idx_q  <= IDX_W'(1);
                  end else begin
                     word_q <= word_ins_d;
                     idx_q  <= idx_q + IDX_W'(1);
                     if (idx_q == IDX_W'(NBYTES - 1)) state_q <= PUSH;
                  end
               end
`ifdef CMD_FIFO_WRITER_TIMEOUT_EN
               else if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_q       <= IDLE;
                  idx_q         <= '0;
                  word_q        <= '0;
                  idle_cnt_q    <= '0;
                  timeout_err_q <= 1'b1;
                  drop_q        <= drop_inc_d;
               end else begin
                  idle_cnt_q <= idle_cnt_q + CNT_W'(1);
               end
`endif
            end
            PUSH: begin
               if (fifo_wr_en) begin
                  state_q <= IDLE;
                  idx_q   <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_fifo_writer.sv
// Directed bench for cmd_fifo_writer: framing, full-FIFO stall, restart, stray bytes,
// backpressure, mid-command reset and (when CMD_FIFO_WRITER_TIMEOUT_EN is defined) timeout.
module tb_cmd_fifo_writer;

   logic        wr_clk = 1'b0;
   logic        wr_rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_frame_start;
   logic        in_ready;
   logic        fifo_wr_en;
   logic [71:0] fifo_wr_data;
   logic        fifo_full;
   logic        fifo_almost_full;
   logic        busy;
   logic [7:0]  drop_count;
   logic        timeout_err;

   int          checks = 0;
   int          errors = 0;
   int          push_cnt = 0;
   logic        full_viol = 1'b0;

   always #5 wr_clk = ~wr_clk;

   cmd_fifo_writer #(
      .WIDTH(72),
      .NBYTES(9),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .wr_clk(wr_clk),
      .wr_rst_n(wr_rst_n),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_frame_start(in_frame_start),
      .in_ready(in_ready),
      .fifo_wr_en(fifo_wr_en),
      .fifo_wr_data(fifo_wr_data),
      .fifo_full(fifo_full),
      .fifo_almost_full(fifo_almost_full),
      .busy(busy),
      .drop_count(drop_count),
      .timeout_err(timeout_err)
   );

   always @(posedge wr_clk) begin
      if (fifo_wr_en) begin
         push_cnt++;
         if (fifo_full) full_viol = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic fs);
      in_valid       = 1'b1;
      in_data        = b;
      in_frame_start = fs;
      tick();
      in_valid       = 1'b0;
      in_frame_start = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      wr_rst_n = 1'b0;
      tick();
      wr_rst_n = 1'b1;
      tick();
   endtask

   initial begin
      wr_rst_n         = 1'b0;
      in_valid         = 1'b0;
      in_data          = 8'h00;
      in_frame_start   = 1'b0;
      fifo_full        = 1'b0;
      fifo_almost_full = 1'b0;
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_wr_en", fifo_wr_en, 0);
      check("rst_drop", drop_count, 0);
      check("rst_data", fifo_wr_data, 0);
      check("rst_timeout", timeout_err, 0);
      fifo_almost_full = 1'b1;
      #1;
      check("rst_in_ready_af", in_ready, 0);
      fifo_almost_full = 1'b0;
      tick();
      wr_rst_n = 1'b1;
      tick();

      // single command, back to back
      for (int i = 1; i <= 9; i++) send(8'(i), i == 1);
      check("single_wr_en", fifo_wr_en, 1);
      check("single_data", fifo_wr_data, 72'h010203040506070809);
      check("single_in_ready", in_ready, 0);
      check("single_busy", busy, 1);
      tick();
      check("single_wr_en_off", fifo_wr_en, 0);
      check("single_push_cnt", push_cnt, 1);
      check("single_idle", busy, 0);

      // push stalled by a full FIFO for 20 cycles
      fifo_full = 1'b1;
      for (int i = 1; i <= 9; i++) send(8'(8'hA0 + i), i == 1);
      for (int c = 0; c < 20; c++) begin
         check("full_no_push", fifo_wr_en, 0);
         check("full_in_ready", in_ready, 0);
         tick();
      end
      check("full_push_cnt_hold", push_cnt, 1);
      fifo_full = 1'b0;
      #1;
      check("full_release_wr_en", fifo_wr_en, 1);
      check("full_release_data", fifo_wr_data, 72'hA1A2A3A4A5A6A7A8A9);
      tick();
      check("full_push_cnt", push_cnt, 2);
      check("full_idle", busy, 0);

      // restart on the fifth byte of a command
      send(8'h10, 1'b1);
      for (int i = 1; i <= 3; i++) send(8'(8'h10 + i), 1'b0);
      send(8'h20, 1'b1);
      for (int i = 1; i <= 8; i++) send(8'(8'h20 + i), 1'b0);
      check("restart_drop", drop_count, 1);
      check("restart_wr_en", fifo_wr_en, 1);
      check("restart_data", fifo_wr_data, 72'h202122232425262728);
      tick();
      check("restart_push_cnt", push_cnt, 3);

      // stray bytes in IDLE
      do_reset();
      check("stray_drop_pre", drop_count, 0);
      send(8'h55, 1'b0);
      send(8'h56, 1'b0);
      send(8'h57, 1'b0);
      check("stray_drop", drop_count, 3);
      check("stray_busy", busy, 0);
      check("stray_wr_en", fifo_wr_en, 0);
      tick();
      check("stray_push_cnt", push_cnt, 3);

      // backpressure from almost-full
      fifo_almost_full = 1'b1;
      #1;
      check("bp_idle_in_ready", in_ready, 0);
      in_valid = 1'b1;
      in_data = 8'h77;
      in_frame_start = 1'b1;
      tick();
      in_valid = 1'b0;
      in_frame_start = 1'b0;
      check("bp_not_accepted", busy, 0);
      check("bp_drop_unchanged", drop_count, 3);
      fifo_almost_full = 1'b0;
      send(8'h31, 1'b1);
      fifo_almost_full = 1'b1;
      #1;
      check("bp_collect_in_ready", in_ready, 1);
      for (int i = 2; i <= 9; i++) send(8'(8'h30 + i), 1'b0);
      check("bp_wr_en", fifo_wr_en, 1);
      check("bp_data", fifo_wr_data, 72'h313233343536373839);
      tick();
      check("bp_push_cnt", push_cnt, 4);
      fifo_almost_full = 1'b0;

      // reset in the middle of a command
      send(8'h41, 1'b1);
      send(8'h42, 1'b0);
      send(8'h43, 1'b0);
      wr_rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_data", fifo_wr_data, 0);
      check("midrst_drop", drop_count, 0);
      check("midrst_wr_en", fifo_wr_en, 0);
      check("midrst_timeout", timeout_err, 0);
      check("midrst_in_ready", in_ready, 1);
      tick();
      wr_rst_n = 1'b1;
      tick();
      for (int i = 1; i <= 9; i++) send(8'(8'h60 + i), i == 1);
      check("midrst_push_wr_en", fifo_wr_en, 1);
      check("midrst_push_data", fifo_wr_data, 72'h616263646566676869);
      tick();
      check("midrst_push_cnt", push_cnt, 5);

`ifdef CMD_FIFO_WRITER_TIMEOUT_EN
      for (int i = 1; i <= 4; i++) send(8'(8'hC0 + i), i == 1);
      for (int c = 1; c <= 15; c++) begin
         tick();
         check("to_no_pulse_yet", timeout_err, 0);
      end
      check("to_still_busy", busy, 1);
      tick();
      check("to_pulse", timeout_err, 1);
      check("to_idle", busy, 0);
      check("to_drop", drop_count, 1);
      tick();
      check("to_pulse_single", timeout_err, 0);
      send(8'hD1, 1'b1);
      send(8'hD2, 1'b0);
      wr_rst_n = 1'b0;
      #1;
      check("to_rst_busy", busy, 0);
      check("to_rst_drop", drop_count, 0);
      check("to_rst_timeout", timeout_err, 0);
      check("to_rst_data", fifo_wr_data, 0);
      tick();
      wr_rst_n = 1'b1;
      tick();
      check("final_push_cnt", push_cnt, 5);
`else
      for (int i = 1; i <= 4; i++) send(8'(8'hC0 + i), i == 1);
      repeat (300) tick();
      check("noto_busy", busy, 1);
      check("noto_timeout", timeout_err, 0);
      check("noto_drop", drop_count, 0);
      for (int i = 5; i <= 9; i++) send(8'(8'hC0 + i), 1'b0);
      check("noto_data", fifo_wr_data, 72'hC1C2C3C4C5C6C7C8C9);
      tick();
      check("final_push_cnt", push_cnt, 6);
`endif
      check("wr_en_while_full", full_viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
